fetch_pc_unit: RTL
==================

# fetch_pc_unit

Parametrised program-counter and fetch-address generator for the instruction-fetch stage. It extends the single-register PC sequencer with sign-extended relative jumps, absolute jumps, and hardware call/return through an internal return-address stack (RAS). It also adds a stall input and sticky stack-error flags. It sits between the decode/control logic, which drives `fetch_control`, and the instruction memory read port, which consumes `pc`.

## Interface
Parameters:
- `ADDR_W`, 10: PC and instruction-address width.
- `OFF_W`, 8: relative jump offset width, two's complement; must satisfy OFF_W ≤ ADDR_W.
- `RAS_DEPTH`, 4: return-address stack entries; must be a power of 2 and ≥ 2.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `stall`  in  1  when 1, all state is frozen and `fetch_control` is ignored.
- `fetch_control`  in  3  fetch mode, decoded below.
- `jump_off`  in  OFF_W  signed relative offset.
- `ext_addr`  in  ADDR_W  absolute target (from register file / decode).
- `clr_err`  in  1  clears the sticky error flags.
- `pc`  out  ADDR_W  instruction memory read address (registered).
- `ras_count`  out  $clog2(RAS_DEPTH)+1  number of valid stack entries.
- `ras_empty`  out  1  ras_count == 0.
- `ras_full`  out  1  ras_count == RAS_DEPTH.
- `ras_ovf`  out  1  sticky: a push occurred while full.
- `ras_unf`  out  1  sticky: a pop occurred while empty.

## Operation
- Modes, applied when `stall`=0 (S = sign-extend `jump_off` to ADDR_W):
  - 000 SEQ: pc ← pc+1.
  - 001 REL: pc ← pc+S.
  - 010 ABS: pc ← ext_addr.
  - 011 CALL: push pc+1; pc ← pc+S.
  - 100 CALLA: push pc+1; pc ← ext_addr.
  - 101 RET: pop; pc ← popped entry.
  - 110/111 reserved: pc unchanged; no stack activity.
- All PC arithmetic is modulo 2^ADDR_W; carry-out is discarded. A push value of all-ones+1 wraps to 0.
- The RAS is a circular buffer with a top pointer and `ras_count`. A push writes at top+1, advances top, and increments the count, which saturates at RAS_DEPTH.
- Push while full: overwrite the oldest entry (circular wrap), count stays RAS_DEPTH, set `ras_ovf`. The most recent RAS_DEPTH returns remain correct.
- Pop while non-empty: return entry[top], move top back, decrement count.
- Pop while empty (RET underflow): pc ← pc+1, count stays 0, set `ras_unf`.
- `clr_err`=1 clears `ras_ovf`/`ras_unf` on the next edge. If a new error occurs in the same cycle, set wins. `clr_err` takes effect even while `stall`=1.
- `stall`=1: pc, stack pointer, count and contents all hold. Error flags hold except for `clr_err`.

## Timing
- Reset (async assert, removal synchronous to `clk`): pc=RESET_PC, ras_count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. Stack contents are don't-care.
- Reset asserted mid-operation discards any in-flight push or pop immediately. There is no partial update.
- Next-PC logic is combinational from registered state and inputs. `pc` shows the new value one cycle after the mode is sampled.
- Pushes and pops complete on the same edge as the PC update. A RET in the cycle directly after a CALL returns that CALL's pc+1; no bypass bubble.
- `ras_empty`/`ras_full` are combinational from `ras_count`. Error flags are registered and change on the same edge as the causing operation.
- Throughput: one mode per cycle, back-to-back, with no dead cycles.

## Test plan
- Reset/SEQ: assert reset mid-count. Expect pc=0 asynchronously. After release, 5×SEQ gives pc=1..5. Counting up from 1023 wraps pc to 0.
- REL sign: pc=100, jump_off=8'hFC → pc=96. pc=100, jump_off=8'h7F → pc=227. pc=2, jump_off=8'hFB → pc=1021.
- Nested calls: at pc=10 CALL +20, then at 30 CALLA ext_addr=500, then RET, RET. Expect pc sequence 30, 500, 31, 11, and ras_count 1, 2, 1, 0.
- Overflow: 5 consecutive CALL at RAS_DEPTH=4. Expect ras_full=1 and ras_ovf=1 after the 5th call. The following 4 RETs return the last 4 pushes in LIFO order; the 5th RET sets ras_unf=1 and gives pc+1.
- Stall/clear: stall=1 with CALL applied for 3 cycles gives pc and ras_count unchanged. clr_err applied in the same cycle as an underflow RET leaves ras_unf=1; clr_err alone the next cycle gives ras_unf=0.
- Reserved modes: 110 and 111 hold pc for 2 cycles with ras_count unchanged and no flags set.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter / fetch address generator with return-address stack
module fetch_pc_unit #(
    parameter int ADDR_W    = 10,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   fetch_control,
    input  logic [OFF_W-1:0]             jump_off,
    input  logic [ADDR_W-1:0]            ext_addr,
    input  logic                         clr_err,
    output logic [ADDR_W-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        MODE_SEQ   = 3'b000,
        MODE_REL   = 3'b001,
        MODE_ABS   = 3'b010,
        MODE_CALL  = 3'b011,
        MODE_CALLA = 3'b100,
        MODE_RET   = 3'b101
    } fetch_mode_t;

    logic [ADDR_W-1:0] stack_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q;
    logic [ADDR_W-1:0] sext_off;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_d;
    logic              push;
    logic              pop;
    logic              ovf_evt;
    logic              unf_evt;

    // Sign-extend the relative offset; arithmetic below wraps modulo 2^ADDR_W.
    assign sext_off = ADDR_W'($signed(jump_off));
    assign pc_inc   = pc + ADDR_W'(1);

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

    // Next-PC and stack-operation decode; a stall suppresses everything.
    always_comb begin
        pc_d    = pc;
        push    = 1'b0;
        pop     = 1'b0;
        unf_evt = 1'b0;
        if (!stall) begin
            case (fetch_control)
                MODE_SEQ:   pc_d = pc_inc;
                MODE_REL:   pc_d = pc + sext_off;
                MODE_ABS:   pc_d = ext_addr;
                MODE_CALL: begin
                    push = 1'b1;
                    pc_d = pc + sext_off;
                end
                MODE_CALLA: begin
                    push = 1'b1;
                    pc_d = ext_addr;
                end
                MODE_RET: begin
                    if (ras_empty) begin
                        pc_d    = pc_inc;
                        unf_evt = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stack_mem[top_q];
                    end
                end
                default: pc_d = pc;
            endcase
        end
        ovf_evt = push && ras_full;
    end

    // PC, stack pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= ADDR_W'(RESET_PC);
            top_q     <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            pc <= pc_d;
            if (push) begin
                top_q <= top_q + PTR_W'(1);
                if (!ras_full) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (pop) begin
                top_q     <= top_q - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
            ras_ovf <= (ras_ovf & ~clr_err) | ovf_evt;
            ras_unf <= (ras_unf & ~clr_err) | unf_evt;
        end
    end

    // Stack storage; when full, top+1 is the oldest entry so a push overwrites it.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_mem[top_q + PTR_W'(1)] <= pc_inc;
        end
    end

endmodule
